// File: rtl/quan_scal_fac_adap_pkg.sv
// Shared constants for the G.726 quantizer scale-factor adaptation block:
// rate encodings, homing values, LIMB bounds and the FUNCTW log-weight tables.
package quan_scal_fac_adap_pkg;

  typedef enum logic [1:0] {
    RATE_40K = 2'd0,
    RATE_32K = 2'd1,
    RATE_24K = 2'd2,
    RATE_16K = 2'd3
  } rate_e;

  localparam logic [12:0] YU_HOME = 13'd544;
  localparam logic [18:0] YL_HOME = 19'd34816;
  localparam logic [12:0] YU_MIN  = 13'd544;
  localparam logic [12:0] YU_MAX  = 13'd5120;

  // WI entries are 12-bit two's complement, indexed by the magnitude IM.
  localparam logic [11:0] WI_40K [16] = '{
    12'd14,  12'd14,  12'd24,  12'd39,  12'd40,  12'd41,  12'd58,  12'd100,
    12'd141, 12'd179, 12'd219, 12'd280, 12'd358, 12'd440, 12'd529, 12'd696
  };
  localparam logic [11:0] WI_32K [8] = '{
    12'd4084, 12'd18, 12'd41, 12'd64, 12'd112, 12'd198, 12'd355, 12'd1122
  };
  localparam logic [11:0] WI_24K [4] = '{12'd4092, 12'd30, 12'd137, 12'd582};
  localparam logic [11:0] WI_16K [2] = '{12'd4074, 12'd439};

endpackage

// File: rtl/quan_scal_funct_w.sv
// FUNCTW: maps the right-justified ADPCM codeword to its log-domain weight WI.
module quan_scal_funct_w
  import quan_scal_fac_adap_pkg::*;
(
  input  logic [4:0]  i_i,
  input  rate_e       rate_i,
  output logic [11:0] wi_o
);

  // The sign bit sits just above the magnitude; a set sign inverts the magnitude.
  logic [3:0] im_40k;
  logic [2:0] im_32k;
  logic [1:0] im_24k;
  logic       im_16k;

  assign im_40k = i_i[3:0] ^ {4{i_i[4]}};
  assign im_32k = i_i[2:0] ^ {3{i_i[3]}};
  assign im_24k = i_i[1:0] ^ {2{i_i[2]}};
  assign im_16k = i_i[0]   ^ i_i[1];

  // NOTE: default assigned before the case so no path leaves wi_o unassigned (no latch).
  always_comb begin
    wi_o = WI_40K[im_40k];
    unique case (rate_i)
      RATE_40K: wi_o = WI_40K[im_40k];
      RATE_32K: wi_o = WI_32K[im_32k];
      RATE_24K: wi_o = WI_24K[im_24k];
      RATE_16K: wi_o = WI_16K[im_16k];
      default:  wi_o = WI_40K[im_40k];
    endcase
  end

endmodule

// File: rtl/quan_scal_mix.sv
// MIX: blends the fast (YU) and slow (YL>>6) scale factors by AL/64.
module quan_scal_mix (
  input  logic [12:0] yu_i,
  input  logic [12:0] yls_i,
  input  logic [6:0]  al_i,
  output logic [12:0] y_o
);

  logic [13:0] dif;
  logic [12:0] difm;
  logic [19:0] prod_full;
  logic [13:0] prodm;
  logic [13:0] prod;

  // The multiply runs on the magnitude so the scaling truncates toward zero.
  assign dif       = {1'b0, yu_i} - {1'b0, yls_i};
  assign difm      = dif[13] ? 13'(14'd0 - dif) : dif[12:0];
  assign prod_full = {7'd0, difm} * {13'd0, al_i};
  assign prodm     = 14'(prod_full >> 6);
  assign prod      = dif[13] ? 14'd0 - prodm : prodm;
  assign y_o       = 13'({1'b0, yls_i} + prod);

endmodule

// File: rtl/quan_scal_fac_adap.sv
// G.726 quantizer scale-factor adaptation: FUNCTW -> FILTD -> LIMB -> FILTE
// update of YU/YL on each sample strobe, with a combinational MIX to Y.
module quan_scal_fac_adap
  import quan_scal_fac_adap_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  I,
  input  logic [1:0]  RATE,
  input  logic [6:0]  AL,
  input  logic        dly_strb,
  output logic [12:0] Y,
  input  logic        test_mode,
  input  logic        scan_enable,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  logic [12:0] yu_q, yu_d;
  logic [18:0] yl_q, yl_d;
  logic [11:0] wi;
  logic [16:0] filtd_dif;
  logic [12:0] filtd_difsx;
  logic [12:0] yut;
  logic [20:0] yl_comp;
  logic [13:0] filte_dif;

  quan_scal_funct_w u_funct_w (
    .i_i    (I),
    .rate_i (rate_e'(RATE)),
    .wi_o   (wi)
  );

  // FILTD: arithmetic shift of the 17-bit difference sign-extends DIF>>5 into 13 bits.
  assign filtd_dif   = {wi, 5'd0} - {4'd0, yu_q};
  assign filtd_difsx = 13'($signed(filtd_dif) >>> 5);
  assign yut         = yu_q + filtd_difsx;

  always_comb begin
    yu_d = yut;
    if (yut < YU_MIN)      yu_d = YU_MIN;
    else if (yut > YU_MAX) yu_d = YU_MAX;
  end

  // FILTE: adds YUP - YL/64 (as a 14-bit modular difference) to the slow state.
  assign yl_comp   = 21'h10_0000 - {2'd0, yl_q};
  assign filte_dif = {1'b0, yu_d} + 14'(yl_comp >> 6);
  assign yl_d      = yl_q + {{5{filte_dif[13]}}, filte_dif};

  // NOTE: state updates use non-blocking assignments; the async reset has priority over the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      yu_q <= YU_HOME;
      yl_q <= YL_HOME;
    end else if (dly_strb) begin
      yu_q <= yu_d;
      yl_q <= yl_d;
    end
  end

  quan_scal_mix u_mix (
    .yu_i  (yu_q),
    .yls_i (yl_q[18:6]),
    .al_i  (AL),
    .y_o   (Y)
  );

  // Scan chains are stitched at synthesis; the DFT inputs have no functional role.
  logic unused_dft;
  assign unused_dft = &{1'b0, test_mode, scan_enable,
                        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

endmodule

// File: tb/tb_quan_scal_fac_adap.sv
// Self-checking bench for quan_scal_fac_adap: hand-computed vector table plus
// hold, saturation and reset-vs-strobe sequences backed by a small arithmetic model.
module tb_quan_scal_fac_adap;

  logic        clk;
  logic        reset;
  logic [4:0]  I;
  logic [1:0]  RATE;
  logic [6:0]  AL;
  logic        dly_strb;
  logic [12:0] Y;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, shadowing YU and YL.
  int m_yu = 544;
  int m_yl = 34816;

  localparam int WI40 [16] = '{14, 14, 24, 39, 40, 41, 58, 100,
                               141, 179, 219, 280, 358, 440, 529, 696};
  localparam int WI32 [8]  = '{-12, 18, 41, 64, 112, 198, 355, 1122};
  localparam int WI24 [4]  = '{-4, 30, 137, 582};
  localparam int WI16 [2]  = '{-22, 439};

  typedef struct {
    bit rst;
    int i;
    int rate;
    int al;
    bit strb;
    int exp_y;
  } vec_t;

  vec_t vecs [26];

  quan_scal_fac_adap dut (
    .clk         (clk),
    .reset       (reset),
    .I           (I),
    .RATE        (RATE),
    .AL          (AL),
    .dly_strb    (dly_strb),
    .Y           (Y),
    .test_mode   (1'b0),
    .scan_enable (1'b0),
    .scan_in0    (1'b0),
    .scan_in1    (1'b0),
    .scan_in2    (1'b0),
    .scan_in3    (1'b0),
    .scan_in4    (1'b0),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act, input int exp);
    n_checks++;
    if ($isunknown(act) || int'(act) != exp) begin
      n_fail++;
      $display("FAIL %s: Y=%0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_wi(input int i, input int rate);
    int is_neg;
    int im;
    case (rate)
      0: begin is_neg = (i >> 4) & 1; im = is_neg ? (~i) & 15 : i & 15; return WI40[im]; end
      1: begin is_neg = (i >> 3) & 1; im = is_neg ? (~i) & 7  : i & 7;  return WI32[im]; end
      2: begin is_neg = (i >> 2) & 1; im = is_neg ? (~i) & 3  : i & 3;  return WI24[im]; end
      default: begin is_neg = (i >> 1) & 1; im = is_neg ? (~i) & 1 : i & 1; return WI16[im]; end
    endcase
  endfunction

  task automatic model_step(input int i, input int rate);
    int wi, d, dsx, yut, yup, dif, dsx2;
    wi  = model_wi(i, rate);
    d   = wi * 32 - m_yu;
    dsx = (d >= 0) ? d / 32 : -((31 - d) / 32);
    yut = (m_yu + dsx + 8192) % 8192;
    yup = (yut < 544) ? 544 : (yut > 5120) ? 5120 : yut;
    dif  = (yup + ((1048576 - m_yl) >> 6)) % 16384;
    dsx2 = (dif >= 8192) ? dif - 16384 : dif;
    m_yl = (m_yl + dsx2 + 524288) % 524288;
    m_yu = yup;
  endtask

  function automatic int model_y(input int al);
    int yls, dif, difm, prodm, prod;
    yls   = m_yl >> 6;
    dif   = (m_yu + 16384 - yls) % 16384;
    difm  = (dif >= 8192) ? (16384 - dif) % 8192 : dif;
    prodm = (difm * al) >> 6;
    prod  = (dif >= 8192) ? (16384 - prodm) % 16384 : prodm;
    return (yls + prod) % 8192;
  endfunction

  task automatic strobe();
    @(negedge clk);
    dly_strb = 1'b1;
    @(negedge clk);
    dly_strb = 1'b0;
    model_step(int'(I), int'(RATE));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    m_yu  = 544;
    m_yl  = 34816;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    dly_strb = 1'b0;
    I        = 5'd0;
    RATE     = 2'd0;
    AL       = 7'd0;

    //           rst  I  rate al strb exp_y
    vecs[0]  = '{1,   0, 1,   0, 0,   544};
    vecs[1]  = '{1,   0, 1,  64, 0,   544};
    vecs[2]  = '{0,   0, 1,  64, 1,   544};   // WI=-12: YUT below 544, LIMB holds 544
    vecs[3]  = '{0,   0, 1,  64, 0,   544};
    vecs[4]  = '{0,   0, 1,   0, 0,   544};
    vecs[5]  = '{0,   0, 1,  32, 0,   544};
    vecs[6]  = '{0,   7, 1,  64, 1,   544};   // WI=1122 -> YU=1649, YL=35921
    vecs[7]  = '{0,   7, 1,  64, 0,  1649};
    vecs[8]  = '{0,   7, 1,   0, 0,   561};
    vecs[9]  = '{0,   7, 1,  32, 0,  1105};
    vecs[10] = '{0,   7, 1,   1, 0,   578};
    vecs[11] = '{1,   7, 1,  64, 0,   544};   // mid-run reset
    vecs[12] = '{0,  15, 0,  64, 1,   544};   // WI=696 -> YU=1223, YL=35495
    vecs[13] = '{0,  15, 0,  64, 0,  1223};
    vecs[14] = '{0,  15, 0,   0, 0,   554};
    vecs[15] = '{0,  15, 0,  16, 0,   721};
    vecs[16] = '{0,   0, 3,  64, 1,  1223};   // WI=-22 -> YU=1162, YL=36102
    vecs[17] = '{0,   0, 3,  64, 0,  1162};
    vecs[18] = '{0,   0, 3,   0, 0,   564};
    vecs[19] = '{0,  27, 2,  64, 1,  1162};   // high bits ignored, WI=582 -> YU=1707, YL=37244
    vecs[20] = '{0,  27, 2,  64, 0,  1707};
    vecs[21] = '{0,  27, 2,   0, 0,   581};
    vecs[22] = '{0,   8, 1,  64, 1,  1707};   // sign set, IM=7 -> YU=2775, YL=39437
    vecs[23] = '{0,   8, 1,  64, 0,  2775};
    vecs[24] = '{0,   8, 1,   0, 0,   616};
    vecs[25] = '{0,   8, 1,  48, 0,  2235};

    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (vecs[k].rst) begin
        reset = 1'b0;
        m_yu  = 544;
        m_yl  = 34816;
      end
      I        = 5'(vecs[k].i);
      RATE     = 2'(vecs[k].rate);
      AL       = 7'(vecs[k].al);
      dly_strb = 1'b0;
      #1;
      check($sformatf("vec%0d", k), Y, vecs[k].exp_y);
      reset = 1'b1;
      if (vecs[k].strb) strobe();
    end

    // Hold: no strobe for 100 cycles while inputs toggle; Y tracks AL alone.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      I    = 5'($urandom);
      RATE = 2'($urandom);
      AL   = 7'($urandom_range(0, 64));
      #1;
      check($sformatf("hold%0d", c), Y, model_y(int'(AL)));
    end
    @(negedge clk);
    AL = 7'd64;
    #1 check("hold_yu", Y, 2775);
    AL = 7'd0;
    #1 check("hold_yls", Y, 616);

    // Saturation high: 40k, I=15 repeatedly.
    do_reset();
    RATE = 2'd0;
    I    = 5'd15;
    for (int s = 0; s < 20; s++) begin
      AL = 7'($urandom_range(0, 64));
      #1 check($sformatf("sat_up%0d", s), Y, model_y(int'(AL)));
      strobe();
    end
    AL = 7'd64;
    #1 check("sat_up_top", Y, 5120);
    for (int s = 0; s < 5; s++) strobe();
    #1 check("sat_up_hold", Y, 5120);

    // Saturation low: I=0 repeatedly; YL lags so MIX sees YU below YL>>6.
    I = 5'd0;
    for (int s = 0; s < 300; s++) begin
      AL = 7'($urandom_range(0, 64));
      #1 check($sformatf("sat_dn%0d", s), Y, model_y(int'(AL)));
      strobe();
    end
    AL = 7'd64;
    #1 check("sat_dn_floor", Y, 544);
    for (int s = 0; s < 5; s++) strobe();
    #1 check("sat_dn_hold", Y, 544);

    // Strobe coinciding with reset is discarded.
    @(negedge clk);
    RATE     = 2'd1;
    I        = 5'd7;
    AL       = 7'd64;
    dly_strb = 1'b1;
    reset    = 1'b0;
    @(negedge clk);
    dly_strb = 1'b0;
    #1 check("rst_vs_strb_yu", Y, 544);
    AL = 7'd0;
    #1 check("rst_vs_strb_yls", Y, 544);
    reset = 1'b1;
    m_yu  = 544;
    m_yl  = 34816;

    // One more update after release confirms the block resumes from homing.
    AL = 7'd64;
    strobe();
    #1 check("post_rst_yu", Y, 1649);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
